// File: rtl/pipeline_occupancy_tracker_if.sv
// Bus bundle for the multi-lane occupancy tracker: per-lane in/out strobes,
// error controls, drain handshake and registered status.
interface pipeline_occupancy_tracker_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
);
  logic [CHANNELS-1:0]           sig_in;
  logic [CHANNELS-1:0]           sig_out;
  logic                          err_clear;
  logic                          drain_req;

  logic [CHANNELS-1:0]           value_in_pipeline;
  logic                          any_in_pipeline;
  logic [CHANNELS-1:0]           full;
  logic [CHANNELS*CNT_WIDTH-1:0] count;
  logic [CHANNELS-1:0]           err_overflow;
  logic [CHANNELS-1:0]           err_underflow;
  logic                          block_in;
  logic                          drain_done;
  logic [1:0]                    dbg_state;

  // Drain handshake is four-phase: drain_req rises, block_in follows, drain_done
  // rises once all lanes are empty, drain_req falls, then drain_done/block_in fall.
  modport master (
    output sig_in, sig_out, err_clear, drain_req,
    input  value_in_pipeline, any_in_pipeline, full, count,
    input  err_overflow, err_underflow, block_in, drain_done, dbg_state
  );

  modport slave (
    input  sig_in, sig_out, err_clear, drain_req,
    output value_in_pipeline, any_in_pipeline, full, count,
    output err_overflow, err_underflow, block_in, drain_done, dbg_state
  );
endinterface

// File: rtl/pipeline_occupancy_tracker.sv
// Per-lane in-flight counters with saturating limits, sticky error flags and a
// drain FSM that blocks upstream and acknowledges once every lane is empty.
module pipeline_occupancy_tracker #(
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int MAX_INFLIGHT = 255
) (
  input  logic                          aclk,
  input  logic                          resetn,
  pipeline_occupancy_tracker_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]                vip_q, vip_d;
  logic [CHANNELS-1:0]                full_q, full_d;
  logic [CHANNELS-1:0]                ovf_q, ovf_d;
  logic [CHANNELS-1:0]                unf_q, unf_d;
  logic                               any_q, any_d;
  state_e                             state_q, state_d;
  logic                               all_empty;
  logic                               io_idle;

  // Counters saturate at both ends; an event that would wrap raises the sticky
  // flag instead, and that flag wins over a simultaneous err_clear.
  always_comb begin
    cnt_d  = cnt_q;
    vip_d  = '0;
    full_d = '0;
    ovf_d  = bus.err_clear ? '0 : ovf_q;
    unf_d  = bus.err_clear ? '0 : unf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      case ({bus.sig_in[c], bus.sig_out[c]})
        2'b10: begin
          if (cnt_q[c] == MAX_C) ovf_d[c] = 1'b1;
          else                   cnt_d[c] = cnt_q[c] + ONE_C;
        end
        2'b01: begin
          if (cnt_q[c] == '0) unf_d[c] = 1'b1;
          else                cnt_d[c] = cnt_q[c] - ONE_C;
        end
        default: ;
      endcase
      // A value passing straight through still occupied the lane this cycle.
      vip_d[c]  = (cnt_d[c] != '0) || (bus.sig_in[c] && bus.sig_out[c]);
      full_d[c] = (cnt_d[c] == MAX_C);
    end
    any_d = |vip_d;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      vip_q  <= '0;
      full_q <= '0;
      ovf_q  <= '0;
      unf_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      vip_q  <= vip_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      any_q  <= any_d;
    end
  end

  assign all_empty = (cnt_q == '0);
  assign io_idle   = (bus.sig_in == '0) && (bus.sig_out == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Withdrawing the request aborts the drain without an acknowledge.
        if (!bus.drain_req)          state_d = ST_IDLE;
        else if (all_empty && io_idle) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.drain_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign bus.count             = cnt_q;
  assign bus.value_in_pipeline = vip_q;
  assign bus.any_in_pipeline   = any_q;
  assign bus.full              = full_q;
  assign bus.err_overflow      = ovf_q;
  assign bus.err_underflow     = unf_q;
  assign bus.block_in          = (state_q != ST_IDLE);
  assign bus.drain_done        = (state_q == ST_DONE);
  assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_pipeline_occupancy_tracker.sv
// Table-driven bench for pipeline_occupancy_tracker (4 lanes, 8-bit counts,
// limit 3) with an expected-value queue compared one cycle after each drive.
module tb_pipeline_occupancy_tracker;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int W  = CH*CW + CH + 1 + CH + CH + CH + 2;

  typedef struct {
    logic          rstn;
    logic [CH-1:0] si;
    logic [CH-1:0] so;
    logic          clr;
    logic          drq;
    logic [31:0]   cnt;
    logic [CH-1:0] vip;
    logic [CH-1:0] full;
    logic [CH-1:0] ovf;
    logic [CH-1:0] unf;
    logic          blk;
    logic          done;
  } vec_t;

  logic aclk;
  logic resetn;
  logic [W-1:0] exp_q[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  pipeline_occupancy_tracker_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus();

  pipeline_occupancy_tracker #(
    .CHANNELS(CH), .CNT_WIDTH(CW), .MAX_INFLIGHT(3)
  ) dut (
    .aclk  (aclk),
    .resetn(resetn),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic rstn, input logic [3:0] si, input logic [3:0] so,
                              input logic clr, input logic drq, input logic [31:0] cnt,
                              input logic [3:0] vip, input logic [3:0] full,
                              input logic [3:0] ovf, input logic [3:0] unf,
                              input logic blk, input logic done);
    vec_t v;
    v.rstn = rstn; v.si = si; v.so = so; v.clr = clr; v.drq = drq;
    v.cnt = cnt; v.vip = vip; v.full = full; v.ovf = ovf; v.unf = unf;
    v.blk = blk; v.done = done;
    tbl.push_back(v);
  endfunction

  function automatic logic [W-1:0] pack_exp(input vec_t v);
    return {v.cnt, v.vip, |v.vip, v.full, v.ovf, v.unf, v.blk, v.done};
  endfunction

  function automatic logic [W-1:0] pack_dut();
    return {bus.count, bus.value_in_pipeline, bus.any_in_pipeline, bus.full,
            bus.err_overflow, bus.err_underflow, bus.block_in, bus.drain_done};
  endfunction

  // scoreboard: pop the oldest expectation and compare with the registered outputs
  task automatic check(input string tag, input int idx);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: expected queue empty, got none required one entry", tag, idx);
      return;
    end
    exp_v = exp_q.pop_front();
    got_v = pack_dut();
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s[%0d] {count,vip,any,full,ovf,unf,blk,done}: got=%h required=%h",
               tag, idx, got_v, exp_v);
    end
  endtask

  // driver: inputs applied away from the edge, outputs sampled 1 time unit after it
  task automatic apply(input vec_t v, input string tag, input int idx);
    resetn        = v.rstn;
    bus.sig_in    = v.si;
    bus.sig_out   = v.so;
    bus.err_clear = v.clr;
    bus.drain_req = v.drq;
    exp_q.push_back(pack_exp(v));
    @(posedge aclk);
    #1;
    check(tag, idx);
  endtask

  initial begin
    resetn = 1'b0;
    bus.sig_in = '0; bus.sig_out = '0; bus.err_clear = 1'b0; bus.drain_req = 1'b0;

    //   rstn si      so      clr drq cnt           vip     full    ovf     unf     blk done
    add(0, 4'h0,   4'h0,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0); // reset
    add(1, 4'h0,   4'h0,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0); // idle
    add(1, 4'h1,   4'h0,   0, 0, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h1,   4'h0,   0, 0, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h1,   4'h0,   0, 0, 32'h00000003, 4'b0001,4'b0001,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h2,   4'h2,   0, 0, 32'h00000000, 4'b0010,4'b0000,4'b0000,4'b0000,0,0); // pass-through at 0
    add(1, 4'h2,   4'h2,   0, 0, 32'h00000000, 4'b0010,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h0,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h4,   4'h0,   0, 0, 32'h00010000, 4'b0100,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h4,   4'h0,   0, 0, 32'h00020000, 4'b0100,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h4,   4'h0,   0, 0, 32'h00030000, 4'b0100,4'b0100,4'b0000,4'b0000,0,0);
    add(1, 4'h4,   4'h0,   0, 0, 32'h00030000, 4'b0100,4'b0100,4'b0100,4'b0000,0,0); // overflow
    add(1, 4'h4,   4'h0,   1, 0, 32'h00030000, 4'b0100,4'b0100,4'b0100,4'b0000,0,0); // clear loses
    add(1, 4'h4,   4'h4,   0, 0, 32'h00030000, 4'b0100,4'b0100,4'b0100,4'b0000,0,0); // in+out at limit
    add(1, 4'h0,   4'h0,   1, 0, 32'h00030000, 4'b0100,4'b0100,4'b0000,4'b0000,0,0); // clear
    add(1, 4'h0,   4'h8,   0, 0, 32'h00030000, 4'b0100,4'b0100,4'b0000,4'b1000,0,0); // underflow
    add(1, 4'h0,   4'h8,   1, 0, 32'h00030000, 4'b0100,4'b0100,4'b0000,4'b1000,0,0); // clear loses
    add(1, 4'h0,   4'h4,   0, 0, 32'h00020000, 4'b0100,4'b0000,4'b0000,4'b1000,0,0);
    add(1, 4'h0,   4'h4,   1, 0, 32'h00010000, 4'b0100,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h4,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'hB,   4'h0,   0, 0, 32'h01000101, 4'b1011,4'b0000,4'b0000,4'b0000,0,0); // multi-lane
    add(1, 4'h1,   4'hA,   0, 0, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);
    // drain with two values in lane 0, one late arrival while draining
    add(1, 4'h1,   4'h0,   0, 0, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h1,   4'h0,   0, 0, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h0,   0, 1, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h1,   4'h0,   0, 1, 32'h00000003, 4'b0001,4'b0001,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h1,   0, 1, 32'h00000002, 4'b0001,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h1,   0, 1, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h1,   0, 1, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h0,   0, 1, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,1,1); // done
    add(1, 4'h0,   4'h0,   0, 1, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,1,1); // held
    add(1, 4'h0,   4'h0,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0); // release
    // pass-through traffic keeps an empty drain from completing
    add(1, 4'h0,   4'h0,   0, 1, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h2,   4'h2,   0, 1, 32'h00000000, 4'b0010,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h0,   0, 1, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,1,1);
    add(1, 4'h0,   4'h0,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);
    // aborted drain: request withdrawn while a value is still in flight
    add(1, 4'h1,   4'h0,   0, 1, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,1,0);
    add(1, 4'h0,   4'h0,   0, 0, 32'h00000001, 4'b0001,4'b0000,4'b0000,4'b0000,0,0);
    add(1, 4'h0,   4'h1,   0, 0, 32'h00000000, 4'b0000,4'b0000,4'b0000,4'b0000,0,0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "vec", i);

    // reset asserted mid-drain with a count of 2 and a sticky error pending
    begin
      vec_t s[4];
      s[0] = '{1, 4'h1, 4'h8, 0, 0, 32'h00000001, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 0, 0};
      s[1] = '{1, 4'h1, 4'h0, 0, 1, 32'h00000002, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 1, 0};
      s[2] = '{0, 4'h1, 4'h0, 0, 1, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
      s[3] = '{1, 4'h0, 4'h0, 0, 0, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
      for (int i = 0; i < 4; i++) apply(s[i], "rst_drain", i);
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending expectations required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
